// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the scrolling 7-segment message display.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package hex_scroll_pkg;

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_SCROLL = 1'b1
    } state_e;

    localparam int CODE_H     = 0;
    localparam int CODE_E     = 1;
    localparam int CODE_L     = 2;
    localparam int CODE_O     = 3;
    localparam int CODE_BLANK = 7;

    localparam logic [6:0] SEG_H     = 7'b000_1001;
    localparam logic [6:0] SEG_E     = 7'b000_0110;
    localparam logic [6:0] SEG_L     = 7'b100_0111;
    localparam logic [6:0] SEG_O     = 7'b100_0000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/hex_scroll_display_seg7_decode.sv
// Combinational character-code to active-low 7-segment decoder.
module seg7_decode
    import hex_scroll_pkg::*;
#(
    parameter int CHAR_W = 3
) (
    input  logic [CHAR_W-1:0] code,
    output logic [6:0]        seg
);

    // Map the four supported letters; every other code is blank
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CHAR_W'(CODE_H): seg = SEG_H;
            CHAR_W'(CODE_E): seg = SEG_E;
            CHAR_W'(CODE_L): seg = SEG_L;
            CHAR_W'(CODE_O): seg = SEG_O;
            default:         seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scroll_display.sv
// Loads a MSG_LEN-character message, then scrolls it across NUM_DIGITS 7-segment digits.
// Optional macro HEX_SCROLL_DIR_EN enables right scrolling via dir; otherwise always left.
module hex_scroll_display
    import hex_scroll_pkg::*;
#(
    parameter int NUM_DIGITS = 7,
    parameter int MSG_LEN    = 8,
    parameter int CHAR_W     = 3,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                    CLOCK_50,
    input  logic                    Resetn,
    input  logic [CHAR_W-1:0]       char_in,
    input  logic                    char_valid,
    output logic                    char_ready,
    input  logic                    load,
    input  logic                    run,
    input  logic                    dir,
    output logic [7*NUM_DIGITS-1:0] HEX
);

    localparam int PTR_W  = $clog2(MSG_LEN);
    localparam int TICK_W = $clog2(TICK_DIV);

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        offset_q, offset_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [CHAR_W-1:0]       msg_q [MSG_LEN];
    logic [CHAR_W-1:0]       msg_d [MSG_LEN];
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [CHAR_W-1:0]       disp_code_s [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] dig_seg_s;
    logic                    step_right_s;
    logic [PTR_W-1:0]        offset_step_s;

`ifdef HEX_SCROLL_DIR_EN
    assign step_right_s = dir;
`else
    logic unused_dir_s;
    assign unused_dir_s = dir;
    assign step_right_s = 1'b0;
`endif

    // Next offset for one scroll step, wrapping within the message
    always_comb begin
        if (step_right_s) begin
            offset_step_s = (offset_q == '0) ? PTR_W'(MSG_LEN - 1) : offset_q - 1'b1;
        end else begin
            offset_step_s = (offset_q == PTR_W'(MSG_LEN - 1)) ? '0 : offset_q + 1'b1;
        end
    end

    // Load/scroll state machine, buffer writes and tick counting; load has top priority
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        offset_d = offset_q;
        tick_d   = tick_q;
        msg_d    = msg_q;
        if (load) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            offset_d = '0;
            tick_d   = '0;
            for (int k = 0; k < MSG_LEN; k++) begin
                msg_d[k] = CHAR_W'(CODE_BLANK);
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (char_valid) begin
                        msg_d[wr_ptr_q] = char_in;
                        if (wr_ptr_q == PTR_W'(MSG_LEN - 1)) begin
                            state_d  = ST_SCROLL;
                            wr_ptr_d = '0;
                            offset_d = '0;
                            tick_d   = '0;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                end
                ST_SCROLL: begin
                    if (run) begin
                        if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                            tick_d   = '0;
                            offset_d = offset_step_s;
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q;
                    end
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // Pick the buffer character shown on each digit; digit NUM_DIGITS-1 is leftmost
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            disp_code_s[i] = msg_q[PTR_W'((32'(offset_q) + 32'(NUM_DIGITS - 1 - i)) % 32'(MSG_LEN))];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_decode #(.CHAR_W(CHAR_W)) u_dec (
            .code (disp_code_s[g]),
            .seg  (dig_seg_s[7*g +: 7])
        );
    end

    // Segment outputs are blank while loading
    always_comb begin
        if (state_q == ST_LOAD) begin
            hex_d = '1;
        end else begin
            hex_d = dig_seg_s;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_LOAD;
            wr_ptr_q <= '0;
            offset_q <= '0;
            tick_q   <= '0;
            hex_q    <= '1;
            for (int k = 0; k < MSG_LEN; k++) begin
                msg_q[k] <= CHAR_W'(CODE_BLANK);
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            offset_q <= offset_d;
            tick_q   <= tick_d;
            hex_q    <= hex_d;
            msg_q    <= msg_d;
        end
    end

    assign char_ready = (state_q == ST_LOAD);
    assign HEX        = hex_q;

endmodule

// File: doc/hex_scroll_display.md
HEX_SCROLL_DISPLAY -- requirements
Module: hex_scroll_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 7: number of 7-segment digits driven.
REQ-002 SHALL have parameter MSG_LEN, default 8: message buffer depth in characters, range 2..16.
REQ-003 SHALL have parameter CHAR_W, default 3: character code width.
REQ-004 SHALL have parameter TICK_DIV, default 50000000: clock cycles per scroll step, minimum 2.
REQ-005 SHALL have port CLOCK_50, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port char_in, input, CHAR_W bits: character code offered for loading.
REQ-008 SHALL have port char_valid, input, 1 bit: char_in is valid this cycle.
REQ-009 SHALL have port char_ready, output, 1 bit: block accepts a character this cycle.
REQ-010 SHALL have port load, input, 1 bit: single-cycle request to restart message loading.
REQ-011 SHALL have port run, input, 1 bit: scrolling enabled while high.
REQ-012 SHALL have port dir, input, 1 bit: scroll direction, 0 = left, 1 = right.
REQ-013 SHALL have port HEX, output, 7*NUM_DIGITS bits: active-low segments; bits [7i+6:7i] drive digit i, digit 0 rightmost.

Function
REQ-014 SHALL implement two states, LOAD and SCROLL.
REQ-015 In LOAD, SHALL hold char_ready=1; in SCROLL, SHALL hold char_ready=0.
REQ-016 SHALL accept a character only on cycles with char_valid && char_ready, writing it to buf[wr_ptr] and incrementing wr_ptr.
REQ-017 When the character at wr_ptr=MSG_LEN-1 is accepted, SHALL move to SCROLL next cycle with offset=0 and tick counter=0.
REQ-018 In SCROLL, SHALL increment the tick counter each cycle while run=1, and hold it while run=0.
REQ-019 When the tick counter reaches TICK_DIV-1, SHALL wrap it to 0 and step offset.
REQ-020 A left step SHALL set offset to (offset+1) mod MSG_LEN; a right step SHALL set it to (offset+MSG_LEN-1) mod MSG_LEN.
REQ-021 Digit i SHALL display buf[(offset + NUM_DIGITS-1-i) mod MSG_LEN], so the buffer reads left to right across the digits.
REQ-022 Character codes SHALL decode as 0=H, 1=E, 2=L, 3=O; all other codes SHALL decode to blank (all segments 1).
REQ-023 HEX SHALL be registered and SHALL reflect the state of the previous cycle (latency 1 cycle).
REQ-024 In LOAD, HEX SHALL show all digits blank.
REQ-025 A load pulse in either state SHALL, next cycle, set state=LOAD, wr_ptr=0, offset=0, tick counter=0, and every buffer entry to code 7.
REQ-026 When load coincides with a character acceptance, SHALL give load priority and discard the character.
REQ-027 When load coincides with a tick, SHALL give load priority and not apply the step.
REQ-028 If NUM_DIGITS > MSG_LEN, the indexing of REQ-021 SHALL wrap, repeating the message.

Reset
REQ-029 Resetn low SHALL immediately set state=LOAD, wr_ptr=0, offset=0, tick counter=0, all buffer entries=7, HEX all 1s and char_ready=1.
REQ-030 Reset asserted mid-load or mid-scroll SHALL discard all buffered characters.

Configuration
REQ-031 With macro HEX_SCROLL_DIR_EN defined, dir SHALL select the scroll direction per REQ-020.
REQ-032 Without HEX_SCROLL_DIR_EN, the dir port SHALL remain present but be ignored, and scrolling SHALL always step left.

Structure
REQ-033 Package hex_scroll_pkg SHALL hold the state enum, the character code constants (H, E, L, O, BLANK) and the active-low segment pattern constants.
REQ-034 Sub-module seg7_decode SHALL be purely combinational (CHAR_W-bit code to 7 segments) and SHALL be instantiated once per digit.

Verification (NUM_DIGITS=7, MSG_LEN=8, TICK_DIV=4)
REQ-035 Reset then stream codes 0,1,2,2,3,7,7,7 with char_valid held high -> char_ready falls after the 8th character; HEX reads "HELLO  " (digit 6 = H) one cycle after entering SCROLL.
REQ-036 run=1, dir=0 -> offset advances every 4 cycles; after 8 steps the display equals the initial pattern.
REQ-037 Define HEX_SCROLL_DIR_EN, set dir=1 -> first step gives offset=7 and digit 6 = blank, digit 5 = H; without the macro the same stimulus steps left.
REQ-038 Drop run to 0 mid-period at tick count 2, hold 10 cycles, raise again -> the next step occurs exactly 2 cycles later.
REQ-039 Pulse load in the same cycle as a tick, and separately in the same cycle as a char acceptance -> state=LOAD, all digits blank, wr_ptr=0, no step applied, character discarded.
REQ-040 Assert Resetn low between clock edges during SCROLL -> HEX goes all 1s with no clock edge, and char_ready=1.
